// File: rtl/caesar_pkg.sv
// Shared types and constants for the Caesar cipher core and its downstream packer.
package caesar_pkg;

    localparam int CHAR_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / CHAR_W;
    localparam int LANE_CNT_W     = $clog2(BYTES_PER_WORD + 1);
    localparam int CNT_W          = 16;

    localparam logic [CHAR_W-1:0] NUL_CHAR = 8'h00;

    typedef struct packed {
        logic [WORD_W-1:0]         word;
        logic [BYTES_PER_WORD-1:0] byte_en;
        logic                      last;
    } ctxt_word_t;

    // Lower n lanes set; n ranges 0..BYTES_PER_WORD.
    function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input logic [LANE_CNT_W-1:0] n);
        logic [BYTES_PER_WORD-1:0] m;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            m[i] = (LANE_CNT_W'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/ctxt_sync_fifo.sv
// Synchronous FIFO of ctxt_word_t with a registered head (first-word-fall-through).
// Capacity DEPTH counts the head register plus the backing array.
module ctxt_sync_fifo
    import caesar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  ctxt_word_t               push_data,
    input  logic                     pop,
    output ctxt_word_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    ctxt_word_t             mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         mem_cnt_q, mem_cnt_d;
    ctxt_word_t             head_q, head_d;
    logic                   head_vld_q, head_vld_d;
    logic                   pop_fire, push_fire, head_free, mem_taken, mem_we;

    assign count = mem_cnt_q + {{PTR_W{1'b0}}, head_vld_q};
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = ~head_vld_q;
    assign rd_data = head_q;

    always_comb begin
        pop_fire   = pop & head_vld_q;
        push_fire  = push & (~full | pop_fire);
        head_free  = ~head_vld_q | pop_fire;
        head_d     = head_q;
        head_vld_d = head_vld_q;
        mem_taken  = 1'b0;
        mem_we     = push_fire;
        if (head_free) begin
            // Older entries in the array always go ahead of a fresh push.
            if (mem_cnt_q != '0) begin
                head_d     = mem_q[rd_ptr_q];
                head_vld_d = 1'b1;
                mem_taken  = 1'b1;
            end else if (push_fire) begin
                head_d     = push_data;
                head_vld_d = 1'b1;
                mem_we     = 1'b0;
            end else begin
                head_vld_d = 1'b0;
            end
        end
        rd_ptr_d  = rd_ptr_q + {{(PTR_W-1){1'b0}}, mem_taken};
        wr_ptr_d  = wr_ptr_q + {{(PTR_W-1){1'b0}}, mem_we};
        mem_cnt_d = mem_cnt_q + {{PTR_W{1'b0}}, mem_we} - {{PTR_W{1'b0}}, mem_taken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ctxt_word_packer.sv
// Packs cipher characters little-endian into 32-bit words and streams them out of a FIFO.
// Optional reject/drop counters are built when CTXT_PACKER_CNT_EN is defined.
module ctxt_word_packer
    import caesar_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_ctx_ready,
    input  logic [CHAR_W-1:0]          in_ctxt_char,
    input  logic                       in_src_valid_d,
    input  logic                       in_flush,
    input  logic                       clr_cnt,
    output logic [WORD_W-1:0]          out_word,
    output logic [BYTES_PER_WORD-1:0]  out_byte_en,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       stall,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int BC_W   = $clog2(BYTES_PER_WORD);
    localparam int HOLD_W = (BYTES_PER_WORD - 1) * CHAR_W;
    localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;

    logic [BC_W-1:0]             byte_cnt_q, byte_cnt_d;
    logic [HOLD_W-1:0]           hold_q, hold_d;
    logic                        stall_q, stall_d;
    logic [WORD_W-1:0]           asm_word;
    logic [WORD_W-1:0]           push_word;
    logic [LANE_CNT_W-1:0]       n_bytes;
    logic [BYTES_PER_WORD-1:0]   push_be;
    logic                        push_en, push_drop, push_ok, pop, reject;
    logic                        fifo_full, fifo_empty;
    logic [OCC_W-1:0]            fifo_count, occ_next;
    ctxt_word_t                  push_entry, head;

    assign n_bytes = {1'b0, byte_cnt_q} + {{BC_W{1'b0}}, in_ctx_ready};
    assign push_be = lane_mask(n_bytes);

    // Incoming character lands in lane byte_cnt; lanes beyond the fill point stay NUL.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi < BYTES_PER_WORD - 1) begin : g_held
                assign asm_word[gi*CHAR_W +: CHAR_W] =
                    (in_ctx_ready && byte_cnt_q == BC_W'(gi)) ? in_ctxt_char : hold_q[gi*CHAR_W +: CHAR_W];
            end else begin : g_top
                assign asm_word[gi*CHAR_W +: CHAR_W] =
                    (in_ctx_ready && byte_cnt_q == BC_W'(gi)) ? in_ctxt_char : NUL_CHAR;
            end
            assign push_word[gi*CHAR_W +: CHAR_W] = push_be[gi] ? asm_word[gi*CHAR_W +: CHAR_W] : NUL_CHAR;
        end
    endgenerate

    always_comb begin
        reject     = in_src_valid_d & ~in_ctx_ready;
        push_en    = in_flush | (in_ctx_ready & (byte_cnt_q == BC_W'(BYTES_PER_WORD - 1)));
        pop        = out_valid & out_ready;
        push_drop  = push_en & fifo_full & ~pop;
        push_ok    = push_en & ~push_drop;
        push_entry = '{word: push_word, byte_en: push_be, last: in_flush};
        occ_next   = fifo_count + {{(OCC_W-1){1'b0}}, push_ok} - {{(OCC_W-1){1'b0}}, pop};
        stall_d    = (occ_next >= OCC_W'(FIFO_DEPTH - 1));
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        // A push (accepted or dropped) always restarts assembly.
        if (push_en) begin
            byte_cnt_d = '0;
            hold_d     = '0;
        end else if (in_ctx_ready) begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            hold_d     = asm_word[HOLD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            hold_q     <= '0;
            stall_q    <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
            stall_q    <= stall_d;
        end
    end

    ctxt_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_en),
        .push_data (push_entry),
        .pop       (out_ready),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_word    = head.word;
    assign out_byte_en = head.byte_en;
    assign out_last    = head.last;
    assign out_valid   = ~fifo_empty;
    assign stall       = stall_q;

`ifdef CTXT_PACKER_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating counters; a clear wins over a coincident increment.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_cnt) begin
            err_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (reject && err_cnt_q != '1)     err_cnt_d  = err_cnt_q + CNT_W'(1);
            if (push_drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{clr_cnt, reject, push_drop};
    assign err_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ctxt_word_packer.sv
// Scoreboard bench for ctxt_word_packer: directed vectors push expected beats, a monitor pops and compares.
module tb_ctxt_word_packer;
    import caesar_pkg::*;

    localparam int DEPTH = 4;
`ifdef CTXT_PACKER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_ctx_ready = 1'b0;
    logic [7:0]        in_ctxt_char = 8'h00;
    logic              in_src_valid_d = 1'b0;
    logic              in_flush = 1'b0;
    logic              clr_cnt = 1'b0;
    logic [31:0]       out_word;
    logic [3:0]        out_byte_en;
    logic              out_last;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              stall;
    logic [15:0]       err_cnt;
    logic [15:0]       drop_cnt;

    ctxt_word_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctxt_word_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_ctx_ready   (in_ctx_ready),
        .in_ctxt_char   (in_ctxt_char),
        .in_src_valid_d (in_src_valid_d),
        .in_flush       (in_flush),
        .clr_cnt        (clr_cnt),
        .out_word       (out_word),
        .out_byte_en    (out_byte_en),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .stall          (stall),
        .err_cnt        (err_cnt),
        .drop_cnt       (drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [31:0] w, input logic [3:0] be, input logic l);
        exp_q.push_back('{word: w, byte_en: be, last: l});
    endtask

    task automatic send(input logic [7:0] c, input logic fl);
        in_ctx_ready   = 1'b1;
        in_src_valid_d = 1'b1;
        in_ctxt_char   = c;
        in_flush       = fl;
        tick();
        in_ctx_ready   = 1'b0;
        in_src_valid_d = 1'b0;
        in_flush       = 1'b0;
    endtask

    task automatic flush_only();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
    endtask

    task automatic reject(input int n);
        in_src_valid_d = 1'b1;
        in_ctx_ready   = 1'b0;
        repeat (n) tick();
        in_src_valid_d = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    // Pops the scoreboard on every handshake and checks hold-stability under backpressure.
    task automatic monitor();
        ctxt_word_t cur, held, e;
        bit was_held = 1'b0;
        forever begin
            @(negedge clk);
            cur = '{word: out_word, byte_en: out_byte_en, last: out_last};
            if (rst_n && was_held && out_valid)
                chk("beat_stable", 64'(cur), 64'(held));
            was_held = rst_n && out_valid && !out_ready;
            held = cur;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(cur), 64'd0 - 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'(cur), 64'(e));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) tick();
        chk("rst_out_word", 64'(out_word), 64'd0);
        chk("rst_byte_en", 64'(out_byte_en), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();

        // Full word, single-cycle latency.
        expect_beat(32'h44434241, 4'hF, 1'b0);
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        send(8'h44, 1'b0);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        drain("t1_drain");

        // Partial word flushed alone.
        expect_beat(32'h00006261, 4'h3, 1'b1);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        flush_only();
        drain("t2_drain");

        // Flush together with the fourth character: exactly one beat.
        expect_beat(32'h45333231, 4'hF, 1'b1);
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        send(8'h45, 1'b1);
        drain("t3_drain");

        // Flush with nothing assembled.
        expect_beat(32'h00000000, 4'h0, 1'b1);
        flush_only();
        drain("t4_drain");

        // Backpressure: 5 words into a 4-deep FIFO, 5th dropped.
        out_ready = 1'b0;
        expect_beat(32'h83828180, 4'hF, 1'b0);
        expect_beat(32'h87868584, 4'hF, 1'b0);
        expect_beat(32'h8b8a8988, 4'hF, 1'b0);
        expect_beat(32'h8f8e8d8c, 4'hF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send(8'h80 + 8'(i), 1'b0);
            if (i == 7)  chk("t5_stall_at_2", 64'(stall), 64'd0);
            if (i == 11) chk("t5_stall_at_3", 64'(stall), 64'd1);
        end
        chk("t5_stall_full", 64'(stall), 64'd1);
        chk("t5_head_word", 64'(out_word), 64'h83828180);
        chk("t5_drop_cnt", 64'(drop_cnt), CNT_EN ? 64'd1 : 64'd0);
        out_ready = 1'b1;
        drain("t5_drain");
        chk("t5_stall_released", 64'(stall), 64'd0);

        // Rejects between two characters leave lanes contiguous.
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("t6_drop_cleared", 64'(drop_cnt), 64'd0);
        expect_beat(32'h00004241, 4'h3, 1'b1);
        send(8'h41, 1'b0);
        reject(3);
        send(8'h42, 1'b0);
        flush_only();
        chk("t6_err_cnt", 64'(err_cnt), CNT_EN ? 64'd3 : 64'd0);
        drain("t6_drain");

        // Reset mid-message discards the partial word.
        send(8'h55, 1'b0);
        send(8'h56, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t7_rst_valid", 64'(out_valid), 64'd0);
        chk("t7_rst_err_cnt", 64'(err_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_beat(32'h00000000, 4'h0, 1'b1);
        flush_only();
        drain("t7_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
